// File: rtl/fetch_unit.sv
// fetch_unit: PC owner and instruction fetch stage with req/ack memory handshake and timeout fault
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PCSrc,
  input  logic [31:0] Result,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  output logic [31:0] Instr,
  output logic        InstrValid,
  output logic [31:0] PC,
  output logic [31:0] PCPlus8,
  output logic        fault
);
  localparam logic [1:0] S_REQ = 2'd0, S_EXEC = 2'd1, S_FAULT = 2'd2;
  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d, instr_q, instr_d;
  logic [7:0]  cnt_q, cnt_d;
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    cnt_d   = cnt_q;
    if (state_q == S_REQ) begin
      if (imem_ack) begin
        state_d = S_EXEC;
        instr_d = imem_rdata;
        cnt_d   = '0;
      end else if (cnt_q == 8'(MAX_WAIT - 1)) begin
        state_d = S_FAULT;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end else if (state_q == S_EXEC && !stall) begin
      state_d = S_REQ;
      pc_d    = PCSrc ? (Result & 32'hFFFF_FFFC) : pc_q + 32'd4;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      cnt_q   <= cnt_d;
    end
  end
  assign imem_req   = state_q == S_REQ;
  assign imem_addr  = pc_q;
  assign Instr      = instr_q;
  assign InstrValid = state_q == S_EXEC;
  assign PC         = pc_q;
  assign PCPlus8    = pc_q + 32'd8;
  assign fault      = state_q == S_FAULT;
endmodule
